// File: rtl/mul_unit_6801_if.sv
// Handshake and data bundle between the 6801 control sequencer and the MUL unit.
//   master (sequencer): drives hold, start, acca, accb; observes busy, done, out_mul, c_out
//   slave  (MUL unit) : the reverse
// WIDTH is the operand width; the product is 2*WIDTH bits.
interface mul_unit_6801_if #(
  parameter int WIDTH = 8
);
  logic               hold;
  logic               start;
  logic [WIDTH-1:0]   acca;
  logic [WIDTH-1:0]   accb;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out_mul;
  logic               c_out;

  modport master (
    output hold, start, acca, accb,
    input  busy, done, out_mul, c_out
  );

  modport slave (
    input  hold, start, acca, accb,
    output busy, done, out_mul, c_out
  );
endinterface

// File: rtl/mul_unit_6801.sv
// Sequential WIDTHxWIDTH unsigned shift-add multiplier for the 6801 MUL instruction.
// One multiplier bit is consumed per clock; the 2*WIDTH-bit product and the
// MUL carry (product bit WIDTH-1) are registered on completion and held until
// the next completion.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mul_unit_6801_if
//           hold (freeze everything), start, acca (multiplicand), accb (multiplier),
//           busy (in RUN), done (one non-held cycle), out_mul (product), c_out (carry)
module mul_unit_6801 #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_unit_6801_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH:0]       r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_out_mul;
  logic                 r_c_out;

  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_shifted;
  logic                 w_last;

  // The adder is WIDTH+1 bits so its carry lands in acc_hi and is shifted
  // down into the product on the same step.
  assign w_addend  = r_acc_lo[0] ? {1'b0, r_mcand} : '0;
  assign w_sum     = r_acc_hi + w_addend;
  assign w_shifted = {w_sum, r_acc_lo} >> 1;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_cnt     <= '0;
      r_out_mul <= '0;
      r_c_out   <= 1'b0;
    end else if (!bus.hold) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_mcand  <= bus.acca;
            r_acc_lo <= bus.accb;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc_hi <= w_shifted[2*WIDTH:WIDTH];
          r_acc_lo <= w_shifted[WIDTH-1:0];
          r_cnt    <= r_cnt + 1'b1;
          // Final step: capture the shifted value directly so the product is
          // visible together with done, one cycle earlier than reading acc_*.
          if (w_last) begin
            r_out_mul <= w_shifted[2*WIDTH-1:0];
            r_c_out   <= w_shifted[WIDTH-1];
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.out_mul = r_out_mul;
  assign bus.c_out   = r_c_out;
endmodule

// File: tb/tb_mul_unit_6801.sv
module tb_mul_unit_6801;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mul_unit_6801_if #(.WIDTH(8)) bus ();

  mul_unit_6801 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (the accepting edge E0).
  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    bus.acca  = a;
    bus.accb  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Tick until done is seen or the budget runs out; n = edges waited.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 40);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    bus.acca  = '0;
    bus.accb  = '0;
    tick();
    tick();
    n_tests++;
    if ({bus.busy, bus.done, bus.c_out, bus.out_mul} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b c=%b out=%h, required all 0",
               bus.busy, bus.done, bus.c_out, bus.out_mul);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    int busy_bad;
    do_start(8'hFF, 8'hFF);
    busy_bad = 0;
    // busy for 8 cycles following E0, no done
    for (int i = 0; i < 7; i++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
      tick();
    end
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
    n_tests++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL basic_busy: %0d bad cycles, required 0", busy_bad);
    end
    wait_done(n);
    n_tests++;
    if (n != 1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d more edges busy=%b, required 1 busy=0", n, bus.busy);
    end
    n_tests++;
    if (bus.out_mul !== 16'hFE01 || bus.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ff_ff: out=%h c=%b, required FE01 c=0", bus.out_mul, bus.c_out);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_mul !== 16'hFE01) begin
      n_fail++;
      $display("FAIL basic_idle_hold: done=%b busy=%b out=%h, required 0 0 FE01",
               bus.done, bus.busy, bus.out_mul);
    end
  endtask

  task automatic test_patterns();
    int n;
    do_start(8'h0C, 8'h0B);
    wait_done(n);
    n_tests++;
    if (n != 8 || bus.out_mul !== 16'h0084 || bus.c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pat_0c_0b: n=%0d out=%h c=%b, required 8 0084 1", n, bus.out_mul, bus.c_out);
    end
    tick();
    do_start(8'h00, 8'h5A);
    wait_done(n);
    n_tests++;
    if (n != 8 || bus.out_mul !== 16'h0000 || bus.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL pat_00_5a: n=%0d out=%h c=%b, required 8 0000 0", n, bus.out_mul, bus.c_out);
    end
    tick();
  endtask

  task automatic test_hold();
    int n;
    do_start(8'h12, 8'h34);
    tick();
    tick();
    tick();
    bus.hold = 1'b1;
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.busy !== 1'b1 || bus.out_mul !== 16'h0000) begin
      n_fail++;
      $display("FAIL hold_run_frozen: busy=%b out=%h, required 1 0000", bus.busy, bus.out_mul);
    end
    bus.hold = 1'b0;
    wait_done(n);
    // 3 + 3 held + n must total 8 + 3
    n_tests++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL hold_latency: done after %0d edges, required 5", n);
    end
    n_tests++;
    if (bus.out_mul !== 16'h03A8 || bus.c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_product: out=%h c=%b, required 03A8 1", bus.out_mul, bus.c_out);
    end
    bus.hold  = 1'b1;
    bus.start = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_done_stretch: done=%b busy=%b, required 1 0", bus.done, bus.busy);
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_mul !== 16'h03A8) begin
      n_fail++;
      $display("FAIL hold_done_release: done=%b busy=%b out=%h, required 0 0 03A8",
               bus.done, bus.busy, bus.out_mul);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(8'h11, 8'h0F);
    tick();
    tick();
    bus.acca  = 8'hAA;
    bus.accb  = 8'h55;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    n_tests++;
    if (n != 5 || bus.out_mul !== 16'h00FF || bus.c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: n=%0d out=%h c=%b, required 5 00FF 1", n, bus.out_mul, bus.c_out);
    end
    do_start(8'h80, 8'h02);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.out_mul !== 16'h00FF) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b done=%b out=%h, required 1 0 00FF",
               bus.busy, bus.done, bus.out_mul);
    end
    wait_done(n);
    n_tests++;
    if (n != 8 || bus.out_mul !== 16'h0100 || bus.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_product: n=%0d out=%h c=%b, required 8 0100 0", n, bus.out_mul, bus.c_out);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int n;
    do_start(8'h33, 8'h33);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_mul !== 16'h0000 || bus.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: busy=%b done=%b out=%h c=%b, required 0 0 0000 0",
               bus.busy, bus.done, bus.out_mul, bus.c_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_start(8'h07, 8'h06);
    wait_done(n);
    n_tests++;
    if (n != 8 || bus.out_mul !== 16'h002A || bus.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart: n=%0d out=%h c=%b, required 8 002A 0", n, bus.out_mul, bus.c_out);
    end
  endtask

  task automatic test_sweep();
    int n;
    int bad;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [7:0]  ca [6] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'hFF, 8'h7F};
    logic [7:0]  cb [6] = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'h01, 8'hFE};
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (i < 6) begin
        a = ca[i];
        b = cb[i];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      prod = 16'(a) * 16'(b);
      do_start(a, b);
      wait_done(n);
      n_tests++;
      if (n != 8 || bus.out_mul !== prod || bus.c_out !== prod[7]) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL sweep_%0d: %h*%h n=%0d out=%h c=%b, required 8 %h %b",
                   i, a, b, n, bus.out_mul, bus.c_out, prod, prod[7]);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_patterns();
    test_hold();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
